// File: rtl/host_loader_pkg.sv
// Shared types and constants for the host record loader.
package host_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

  // Byte counter must index the longer of the two fields, and never be zero bits wide.
  function automatic int cnt_width(input int a_bytes, input int d_bytes);
    int m;
    m = (a_bytes > d_bytes) ? a_bytes : d_bytes;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/host_loader_if.sv
// Byte-stream, Wishbone master and status signals of host_loader, bundled with master/slave views.
interface host_loader_if #(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;

  logic [7:0]      data_i;
  logic            valid_i;
  logic            ack_data;
  logic            done_i;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic            wb_we_o;
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic [2:0]      wb_cti_o;
  logic [1:0]      wb_bte_o;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic            ack_o;
  logic            err_o;
  logic            hostctrl_cpu_rst;

  modport master (
    input  data_i, valid_i, done_i, wb_ack_i, wb_err_i,
    output ack_data, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_cti_o, wb_bte_o, ack_o, err_o, hostctrl_cpu_rst
  );

  modport slave (
    output data_i, valid_i, done_i, wb_ack_i, wb_err_i,
    input  ack_data, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
           wb_cti_o, wb_bte_o, ack_o, err_o, hostctrl_cpu_rst
  );

endinterface

// File: rtl/host_loader_wb_wr.sv
// Single-write Wishbone classic master with a bounded wait for ack/err.
module host_loader_wb_wr
  import host_loader_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int WB_TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [AW-1:0]   adr_i,
  input  logic [DW-1:0]   dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_we_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            done_o,
  output logic            ok_o,
  output logic            err_o
);

  localparam logic [15:0] TO_LAST = 16'(WB_TIMEOUT - 1);

  logic [15:0] r_to;
  logic        w_timeout;
  logic        w_term;

  // The cycle is held for at most WB_TIMEOUT cycles; ack in the last one still counts.
  assign w_timeout = (r_to == TO_LAST);
  assign w_term    = wb_cyc_o & (wb_ack_i | wb_err_i | w_timeout);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      done_o   <= 1'b0;
      ok_o     <= 1'b0;
      err_o    <= 1'b0;
      r_to     <= '0;
    end else begin
      done_o <= 1'b0;
      ok_o   <= 1'b0;
      err_o  <= 1'b0;
      if (start_i && !wb_cyc_o) begin
        wb_adr_o <= adr_i;
        wb_dat_o <= dat_i;
        wb_sel_o <= '1;
        wb_we_o  <= 1'b1;
        wb_cyc_o <= 1'b1;
        wb_stb_o <= 1'b1;
        r_to     <= '0;
      end else if (w_term) begin
        wb_sel_o <= '0;
        wb_we_o  <= 1'b0;
        wb_cyc_o <= 1'b0;
        wb_stb_o <= 1'b0;
        done_o   <= 1'b1;
        ok_o     <= wb_ack_i & ~wb_err_i;
        err_o    <= wb_err_i | ~wb_ack_i;
      end else if (wb_cyc_o) begin
        r_to <= r_to + 16'd1;
      end
    end
  end

endmodule

// File: rtl/host_loader.sv
// Assembles little-endian {address, data} records from a byte stream and writes each over Wishbone.
// Build option HOST_LOADER_CHECKSUM_EN: each record carries a trailing byte making the byte sum 0x00.
module host_loader
  import host_loader_pkg::*;
#(
  parameter int ADDR_BYTES = 4,
  parameter int DATA_BYTES = 4,
  parameter int WB_TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  host_loader_if.master bus
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  localparam int CW = cnt_width(ADDR_BYTES, DATA_BYTES);
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_BYTES - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BYTES - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_addr, w_addr_nx;
  logic [DW-1:0] r_dat, w_dat_nx;
  logic          r_cpu_rst;
  logic          r_err;
  logic          w_accept, w_addr_last, w_data_last, w_start;
  logic          w_wr_done, w_wr_ok, w_wr_err;

  assign w_addr_last = (r_cnt == ADDR_LAST);
  assign w_data_last = (r_cnt == DATA_LAST);

`ifdef HOST_LOADER_CHECKSUM_EN
  logic [7:0] r_sum, w_sum_nx;
  assign w_sum_nx = r_sum + bus.data_i;
  assign w_accept = bus.valid_i & (r_state == ADDR | r_state == DATA | r_state == CHK);
  assign w_start  = w_accept & (r_state == CHK) & (w_sum_nx == 8'h00);
`else
  assign w_accept = bus.valid_i & (r_state == ADDR | r_state == DATA);
  assign w_start  = w_accept & (r_state == DATA) & w_data_last;
`endif

  // Field images including the byte being accepted, so the bus write can launch on the same edge.
  always_comb begin
    w_addr_nx = r_addr;
    w_dat_nx  = r_dat;
    for (int k = 0; k < ADDR_BYTES; k++)
      if (r_state == ADDR && r_cnt == CW'(k)) w_addr_nx[8*k +: 8] = bus.data_i;
    for (int k = 0; k < DATA_BYTES; k++)
      if (r_state == DATA && r_cnt == CW'(k)) w_dat_nx[8*k +: 8] = bus.data_i;
  end

  always_ff @(posedge clk_i) begin
    if (w_accept && r_state == ADDR) r_addr <= w_addr_nx;
    if (w_accept && r_state == DATA) r_dat  <= w_dat_nx;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_cpu_rst <= 1'b0;
      r_err     <= 1'b0;
`ifdef HOST_LOADER_CHECKSUM_EN
      r_sum     <= 8'h00;
`endif
    end else begin
      if (w_wr_err) r_err <= 1'b1;
`ifdef HOST_LOADER_CHECKSUM_EN
      if (w_accept) r_sum <= (r_state == CHK) ? 8'h00 : w_sum_nx;
      else if (r_state == IDLE || r_state == BUS) r_sum <= 8'h00;
`endif
      case (r_state)
        IDLE: if (!bus.done_i) begin
          r_state   <= ADDR;
          r_cpu_rst <= 1'b1;
        end
        ADDR: if (w_accept) begin
          if (w_addr_last) begin
            r_cnt   <= '0;
            r_state <= DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: if (w_accept) begin
          if (w_data_last) begin
            r_cnt <= '0;
`ifdef HOST_LOADER_CHECKSUM_EN
            r_state <= CHK;
`else
            r_state <= BUS;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
`ifdef HOST_LOADER_CHECKSUM_EN
        CHK: if (w_accept) begin
          if (w_sum_nx == 8'h00) begin
            r_state <= BUS;
          end else begin
            r_err <= 1'b1;
            if (bus.done_i) begin
              r_state   <= IDLE;
              r_cpu_rst <= 1'b0;
            end else begin
              r_state <= ADDR;
            end
          end
        end
`endif
        BUS: if (w_wr_done) begin
          if (bus.done_i) begin
            r_state   <= IDLE;
            r_cpu_rst <= 1'b0;
          end else begin
            r_state <= ADDR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  host_loader_wb_wr #(
    .AW         (AW),
    .DW         (DW),
    .WB_TIMEOUT (WB_TIMEOUT)
  ) u_wr (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (w_start),
    .adr_i    (r_addr),
    .dat_i    (w_dat_nx),
    .wb_ack_i (bus.wb_ack_i),
    .wb_err_i (bus.wb_err_i),
    .wb_adr_o (bus.wb_adr_o),
    .wb_dat_o (bus.wb_dat_o),
    .wb_sel_o (bus.wb_sel_o),
    .wb_we_o  (bus.wb_we_o),
    .wb_cyc_o (bus.wb_cyc_o),
    .wb_stb_o (bus.wb_stb_o),
    .done_o   (w_wr_done),
    .ok_o     (w_wr_ok),
    .err_o    (w_wr_err)
  );

  assign bus.ack_data         = w_accept;
  assign bus.ack_o            = w_wr_ok;
  assign bus.err_o            = r_err;
  assign bus.hostctrl_cpu_rst = r_cpu_rst;
  assign bus.wb_cti_o         = WB_CTI_CLASSIC;
  assign bus.wb_bte_o         = WB_BTE_LINEAR;

endmodule
